apb_bus_arbiter: RTL and testbench

APB master front end that shares the single APB bus between two requesters (requester 0: host command port, requester 1: test/DMA port) and sequences every transfer through the APB IDLE → SETUP → ACCESS phases toward the GPIO slave (psel 01) and UART slave (psel 10). It performs round-robin arbitration, drives psel/penable/paddr/pwrite/pwdata, and waits on pready. It aborts transfers whose slave never responds (for example, a full UART TX FIFO) after a bounded timeout. Each completed transfer returns one tagged response.

---
 rtl/apb_bus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_apb_bus_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_bus_arbiter.sv
// APB master front end: round-robin arbitration between two requesters,
// IDLE/SETUP/ACCESS sequencing, bounded pready wait, one tagged response per transfer.
module apb_bus_arbiter #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              Reset,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [1:0]        req0_sel,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [1:0]        req1_sel,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic [1:0]        psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_last_grant;
  logic [1:0]        r_sel;
  logic              r_id;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic              r_rsp_id;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [1:0]        r_rsp_err;

  logic              w_grant0;
  logic              w_grant1;
  logic              w_accept;
  logic              w_acc_id;
  logic              w_acc_write;
  logic [1:0]        w_acc_sel;
  logic [ADDR_W-1:0] w_acc_addr;
  logic [DATA_W-1:0] w_acc_wdata;
  logic              w_sel_ok;
  logic              w_done;
  logic              w_tmo;

  // Round-robin grant and mux of the winning request fields
  always_comb begin
    w_grant0    = req0_valid && (!req1_valid || r_last_grant);
    w_grant1    = req1_valid && (!req0_valid || !r_last_grant);
    w_accept    = (r_state == S_IDLE) && (w_grant0 || w_grant1);
    w_acc_id    = w_grant1;
    w_acc_write = w_grant1 ? req1_write : req0_write;
    w_acc_sel   = w_grant1 ? req1_sel   : req0_sel;
    w_acc_addr  = w_grant1 ? req1_addr  : req0_addr;
    w_acc_wdata = w_grant1 ? req1_wdata : req0_wdata;
    w_sel_ok    = (w_acc_sel == 2'b01) || (w_acc_sel == 2'b10);
    w_done      = (r_state == S_ACCESS) && pready;
    w_tmo       = (r_state == S_ACCESS) && !pready && (r_cnt == CNT_LAST);
  end

  // FSM state register
  always_ff @(posedge pclk) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_accept && w_sel_ok) w_next = S_SETUP;
      S_SETUP:  w_next = S_ACCESS;
      S_ACCESS: if (w_done || w_tmo) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // FSM outputs: accept strobes and APB control phases
  always_comb begin
    req0_ready = (r_state == S_IDLE) && w_grant0;
    req1_ready = (r_state == S_IDLE) && w_grant1;
    psel       = (r_state == S_IDLE) ? 2'b00 : r_sel;
    penable    = (r_state == S_ACCESS);
  end

  // Request capture, wait counter, response generation
  always_ff @(posedge pclk) begin
    if (Reset) begin
      r_last_grant <= 1'b1;
      r_sel        <= '0;
      r_id         <= 1'b0;
      r_cnt        <= '0;
      r_pwrite     <= 1'b0;
      r_paddr      <= '0;
      r_pwdata     <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_err    <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_accept) begin
        r_last_grant <= w_acc_id;
        r_id         <= w_acc_id;
        r_sel        <= w_acc_sel;
        if (w_sel_ok) begin
          // APB address/data only move when a real bus cycle follows
          r_pwrite <= w_acc_write;
          r_paddr  <= w_acc_addr;
          r_pwdata <= w_acc_wdata;
          r_cnt    <= '0;
        end else begin
          r_rsp_valid <= 1'b1;
          r_rsp_id    <= w_acc_id;
          r_rsp_err   <= 2'b11;
          r_rsp_rdata <= '0;
        end
      end
      if (r_state == S_ACCESS && !pready) r_cnt <= r_cnt + 1'b1;
      if (w_done) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= r_id;
        r_rsp_err   <= pslverr ? 2'b01 : 2'b00;
        r_rsp_rdata <= (!r_pwrite && !pslverr) ? prdata : '0;
      end else if (w_tmo) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= r_id;
        r_rsp_err   <= 2'b10;
        r_rsp_rdata <= '0;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// Directed self-checking bench for apb_bus_arbiter.
module tb_apb_bus_arbiter;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              pclk = 1'b0;
  logic              Reset;
  logic              req0_valid, req0_write, req1_valid, req1_write;
  logic [1:0]        req0_sel, req1_sel;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic [DATA_W-1:0] req0_wdata, req1_wdata;
  logic              req0_ready, req1_ready;
  logic              rsp_valid, rsp_id;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_err;
  logic [1:0]        psel;
  logic              penable, pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready, pslverr;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  apb_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .Reset(Reset),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_sel(req0_sel),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_sel(req1_sel),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  // advance to the next cycle; outputs settle 1 time unit after the edge
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_write = 0; req0_sel = 2'b00; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_write = 0; req1_sel = 2'b00; req1_addr = '0; req1_wdata = '0;
    prdata = '0; pready = 1; pslverr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    Reset = 1;
    tick(); tick();
    Reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (psel !== 2'b00 || penable !== 1'b0 || pwrite !== 1'b0 || paddr !== '0 || pwdata !== '0) begin
      errors++;
      $display("FAIL reset_apb: psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h, expected all zero",
               psel, penable, pwrite, paddr, pwdata);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_rdata !== '0 || rsp_err !== 2'b00) begin
      errors++;
      $display("FAIL reset_rsp: valid=%b id=%b rdata=%h err=%b, expected all zero",
               rsp_valid, rsp_id, rsp_rdata, rsp_err);
    end
  endtask

  task automatic test_write_zero_wait();
    req0_valid = 1; req0_write = 1; req0_sel = 2'b01; req0_addr = 5'd1; req0_wdata = 32'hABCD1234;
    pready = 1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL wr_accept: ready0=%b ready1=%b, expected 1 0", req0_ready, req1_ready);
    end
    tick(); req0_valid = 0;                                  // T+1
    checks++;
    if (psel !== 2'b01 || penable !== 1'b0 || paddr !== 5'd1 || pwrite !== 1'b1 || pwdata !== 32'hABCD1234) begin
      errors++;
      $display("FAIL wr_setup: psel=%b pen=%b paddr=%h pwrite=%b pwdata=%h, expected 01 0 01 1 abcd1234",
               psel, penable, paddr, pwrite, pwdata);
    end
    tick();                                                  // T+2
    checks++;
    if (psel !== 2'b01 || penable !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_access: psel=%b pen=%b rsp_valid=%b, expected 01 1 0", psel, penable, rsp_valid);
    end
    tick();                                                  // T+3
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_err !== 2'b00 || rsp_rdata !== '0 || psel !== 2'b00 || penable !== 1'b0) begin
      errors++;
      $display("FAIL wr_rsp: valid=%b id=%b err=%b rdata=%h psel=%b pen=%b, expected 1 0 00 0 00 0",
               rsp_valid, rsp_id, rsp_err, rsp_rdata, psel, penable);
    end
    tick();                                                  // T+4
    checks++;
    if (rsp_valid !== 1'b0 || rsp_err !== 2'b00 || paddr !== 5'd1) begin
      errors++;
      $display("FAIL wr_rsp_pulse: valid=%b err=%b paddr=%h, expected 0 00 01", rsp_valid, rsp_err, paddr);
    end
  endtask

  task automatic test_read_wait();
    req0_valid = 1; req0_write = 0; req0_sel = 2'b01; req0_addr = 5'd1;
    pready = 0; prdata = 32'h0;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL rd_accept: ready0=%b, expected 1", req0_ready);
    end
    tick(); req0_valid = 0;          // T+1 SETUP
    tick();                          // T+2 ACCESS wait 1
    tick();                          // T+3 ACCESS wait 2
    checks++;
    if (penable !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rd_wait: pen=%b rsp_valid=%b, expected 1 0", penable, rsp_valid);
    end
    tick();                          // T+4 slave ready
    pready = 1; prdata = 32'hABCD1234;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rd_early: rsp_valid=%b, expected 0", rsp_valid);
    end
    tick();                          // T+5
    prdata = 32'h0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hABCD1234 || rsp_err !== 2'b00 || rsp_id !== 1'b0) begin
      errors++;
      $display("FAIL rd_rsp: valid=%b rdata=%h err=%b id=%b, expected 1 abcd1234 00 0",
               rsp_valid, rsp_rdata, rsp_err, rsp_id);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic exp_id;
    do_reset();
    req0_valid = 1; req0_write = 1; req0_sel = 2'b01; req0_addr = 5'd2; req0_wdata = 32'h0000_0002;
    req1_valid = 1; req1_write = 1; req1_sel = 2'b10; req1_addr = 5'd3; req1_wdata = 32'h0000_0003;
    pready = 1;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_id = (i % 2) == 1;
      checks++;
      if (req0_ready !== !exp_id || req1_ready !== exp_id) begin
        errors++;
        $display("FAIL rr_grant%0d: ready0=%b ready1=%b, expected %b %b", i, req0_ready, req1_ready, !exp_id, exp_id);
      end
      tick();
      checks++;
      if (paddr !== (exp_id ? 5'd3 : 5'd2) || psel !== (exp_id ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL rr_setup%0d: paddr=%h psel=%b, expected %h %b", i, paddr, psel,
                 exp_id ? 5'd3 : 5'd2, exp_id ? 2'b10 : 2'b01);
      end
      tick(); tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_err !== 2'b00) begin
        errors++;
        $display("FAIL rr_rsp%0d: valid=%b id=%b err=%b, expected 1 %b 00", i, rsp_valid, rsp_id, rsp_err, exp_id);
      end
    end
    req0_valid = 0; req1_valid = 0;
    tick();
  endtask

  task automatic test_timeout();
    int bad;
    do_reset();
    req1_valid = 1; req1_write = 1; req1_sel = 2'b10; req1_addr = 5'd4; req1_wdata = 32'h55;
    pready = 0;
    #1;
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++; $display("FAIL to_accept: ready1=%b, expected 1", req1_ready);
    end
    tick(); req1_valid = 0;                       // T+1
    bad = 0;
    for (int c = 2; c <= TIMEOUT + 1; c++) begin  // T+2 .. T+17 ACCESS
      tick();
      if (rsp_valid !== 1'b0 || psel !== 2'b10 || penable !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL to_wait: %0d bad ACCESS cycles, expected 0", bad);
    end
    tick();                                       // T+18
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 2'b10 || rsp_id !== 1'b1 || rsp_rdata !== '0 || psel !== 2'b00 || penable !== 1'b0) begin
      errors++;
      $display("FAIL to_rsp: valid=%b err=%b id=%b rdata=%h psel=%b pen=%b, expected 1 10 1 0 00 0",
               rsp_valid, rsp_err, rsp_id, rsp_rdata, psel, penable);
    end
    // follow-up read from requester 0 completes normally
    pready = 1; prdata = 32'h1234_5678;
    req0_valid = 1; req0_write = 0; req0_sel = 2'b01; req0_addr = 5'd6;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL to_next_accept: ready0=%b, expected 1", req0_ready);
    end
    tick(); req0_valid = 0;
    tick(); tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 2'b00 || rsp_id !== 1'b0 || rsp_rdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL to_next_rsp: valid=%b err=%b id=%b rdata=%h, expected 1 00 0 12345678",
               rsp_valid, rsp_err, rsp_id, rsp_rdata);
    end
    prdata = '0;
    tick();
  endtask

  task automatic test_bad_sel_and_slverr();
    req0_valid = 1; req0_write = 1; req0_sel = 2'b11; req0_addr = 5'd9; req0_wdata = 32'hFFFF;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || psel !== 2'b00) begin
      errors++; $display("FAIL bs_accept: ready0=%b psel=%b, expected 1 00", req0_ready, psel);
    end
    tick(); req0_valid = 0;                       // T+1
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 2'b11 || rsp_id !== 1'b0 || psel !== 2'b00 || paddr !== 5'd6) begin
      errors++;
      $display("FAIL bs_rsp: valid=%b err=%b id=%b psel=%b paddr=%h, expected 1 11 0 00 06",
               rsp_valid, rsp_err, rsp_id, psel, paddr);
    end
    tick();                                       // T+2
    checks++;
    if (rsp_valid !== 1'b0 || psel !== 2'b00) begin
      errors++; $display("FAIL bs_after: valid=%b psel=%b, expected 0 00", rsp_valid, psel);
    end
    // pslverr on a read: err 01, rdata forced to zero
    req1_valid = 1; req1_write = 0; req1_sel = 2'b10; req1_addr = 5'd2;
    pready = 1; pslverr = 1; prdata = 32'hDEADBEEF;
    tick(); req1_valid = 0;
    tick(); tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 2'b01 || rsp_rdata !== '0 || rsp_id !== 1'b1) begin
      errors++;
      $display("FAIL slverr_rsp: valid=%b err=%b rdata=%h id=%b, expected 1 01 0 1",
               rsp_valid, rsp_err, rsp_rdata, rsp_id);
    end
    pslverr = 0; prdata = '0;
    tick();
  endtask

  task automatic test_reset_mid_access();
    req0_valid = 1; req0_write = 1; req0_sel = 2'b01; req0_addr = 5'd7; req0_wdata = 32'h77;
    pready = 0;
    tick(); req0_valid = 0;                       // T+1
    tick();                                       // T+2 ACCESS
    checks++;
    if (penable !== 1'b1) begin
      errors++; $display("FAIL rm_access: pen=%b, expected 1", penable);
    end
    Reset = 1;
    req1_valid = 1; req1_write = 1; req1_sel = 2'b10; req1_addr = 5'd8; req1_wdata = 32'h88;
    tick();                                       // T+3
    Reset = 0;
    #1;
    checks++;
    if (psel !== 2'b00 || penable !== 1'b0 || rsp_valid !== 1'b0 || req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL rm_reset: psel=%b pen=%b rsp_valid=%b ready1=%b, expected 00 0 0 1",
               psel, penable, rsp_valid, req1_ready);
    end
    tick(); req1_valid = 0;                       // T+4
    checks++;
    if (psel !== 2'b10 || paddr !== 5'd8 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rm_pending: psel=%b paddr=%h rsp_valid=%b, expected 10 08 0", psel, paddr, rsp_valid);
    end
    pready = 1;
    tick(); tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_err !== 2'b00) begin
      errors++;
      $display("FAIL rm_rsp: valid=%b id=%b err=%b, expected 1 1 00", rsp_valid, rsp_id, rsp_err);
    end
    tick();
  endtask

  initial begin
    Reset = 1;
    idle_inputs();
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_round_robin();
    test_timeout();
    test_bad_sel_and_slverr();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
